// File: rtl/nios_sys_onchip_mem_arbiter.sv
// nios_sys_onchip_mem_arbiter: round-robin arbiter sharing one single-port RAM between two Avalon-MM masters
module nios_sys_onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);
  logic req0, req1, any, g, owner, rd_pend, rd_src;
  logic [3:0] hold_cnt;
  // g selects m1; with no request it falls to 0 so the mux idles on m0
  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    any = req0 | req1;
    g = (req0 & req1) ? ((hold_cnt < 4'(MAX_HOLD)) ? owner : ~owner) : req1;
    m0_waitrequest = req0 & g;
    m1_waitrequest = req1 & ~g;
    mem_address = g ? m1_address : m0_address;
    mem_byteenable = g ? m1_byteenable : m0_byteenable;
    mem_writedata = g ? m1_writedata : m0_writedata;
    mem_write = g ? m1_write : m0_write;
    mem_chipselect = any;
    m0_readdata = mem_readdata;
    m1_readdata = mem_readdata;
    m0_readdatavalid = rd_pend & ~rd_src & ~reset;
    m1_readdatavalid = rd_pend & rd_src & ~reset;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= 1'b0;
      hold_cnt <= 4'd0;
      rd_pend <= 1'b0;
      rd_src <= 1'b0;
    end else begin
      rd_pend <= any & ~mem_write;
      rd_src <= g;
      if (any) begin
        owner <= g;
        hold_cnt <= (g != owner) ? 4'd1 : ((hold_cnt == 4'hF) ? hold_cnt : hold_cnt + 4'd1);
      end
    end
  end
endmodule

// File: doc/nios_sys_onchip_mem_arbiter.md
Name: nios_sys_onchip_mem_arbiter

Overview:
- Shares one single-port 8192x32 on-chip RAM (13-bit word address, 4 byte enables, 1-cycle read latency) between two Avalon-MM masters.
  - m0: CPU data master.
  - m1: DMA/peripheral master.
- Grants at most one access per cycle using round-robin with a bounded hold count.
- Returns read data to the issuing master with a matching readdatavalid pulse.
- Sits between the interconnect and the RAM's s1 slave port.

Parameters:
- ADDR_W, 13, word address width of masters and RAM.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_HOLD, 4, max consecutive grants to one master while the other is waiting (range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  DATA_W/8  master 0 byte lanes
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data valid
- m1_* (same seven signals)  —  master 1, identical semantics
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  DATA_W/8  RAM byte enables
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_writedata  out  DATA_W  RAM write data
- mem_readdata  in  DATA_W  RAM q output, valid the cycle after the address is presented

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous, active-high.
- Request: reqN = mN_read | mN_write. If both read and write are asserted, the access is treated as a write.
- Arbitration state: owner (1 bit) and hold_cnt (4 bits).
  - Reset: owner=0, hold_cnt=0, both readdatavalid=0, rd_pend=0.
- Grant, combinational from reqs and state:
  - Only one req asserted: grant that master.
  - Both asserted: grant owner if hold_cnt < MAX_HOLD, else grant ~owner.
  - Neither asserted: no grant; state unchanged.
- State update on a grant g:
  - g == owner: hold_cnt <= sat(hold_cnt+1), saturating at 15.
  - g != owner: owner <= g, hold_cnt <= 1.
  - Effect: a lone requester is never stalled. With MAX_HOLD=1, contending masters strictly alternate.
- mN_waitrequest = reqN & ~grantN, combinational, same cycle. A transfer is accepted on a cycle where req=1 and waitrequest=0.
- Memory mux:
  - mem_* is driven from the granted master.
  - mem_chipselect = any grant.
  - mem_write = granted master's write.
  - When there is no grant, mem_chipselect=0 and mem_write=0. Address and data are don't-care but are driven from m0.
- Read return:
  - An accepted read registers rd_pend=1 and rd_src=g.
  - Next cycle: m{rd_src}_readdatavalid=1 and its readdata=mem_readdata. Latency is exactly 1 cycle after acceptance.
  - The other master's readdatavalid stays 0. Both readdata ports may carry mem_readdata; masters use readdatavalid only.
  - Back-to-back accepted reads produce back-to-back valid pulses; there is no bubble.
- Writes: complete on acceptance. No response and no readdatavalid.
- Read-during-write: cannot occur, because there is a single port and one access per cycle.
- Reset mid-operation: a read accepted in the cycle reset is asserted produces no readdatavalid. Arbitration restarts with m0 preferred.
- Outputs during reset: both readdatavalid=0. waitrequest still follows the combinational rule, using the reset state.
- No internal buffering. Masters hold address, data and controls stable while waitrequest=1 (Avalon rule).

Test Plan:
- Single master read: m0 writes 0xDEADBEEF to addr 0x0010 with be=0xF, then reads 0x0010. Required: waitrequest=0 both cycles; m0_readdatavalid high exactly 1 cycle after read acceptance with data 0xDEADBEEF; m1_readdatavalid stays 0.
- Byte enables: write 0x11223344 to 0x1FFF, then write 0xAABBCCDD with be=0x2 to the same address, then read 0x1FFF. Required: readdata=0x1122CC44.
- Contention, MAX_HOLD=4: m0 and m1 both issue continuous reads from reset. Required grant sequence m0 x4, m1 x4, m0 x4. Each waitrequest is high exactly on the other's grant cycles. Readdatavalid routes to the correct master every cycle.
- Lone requester: m1 issues 20 back-to-back reads while m0 is idle. Required: m1_waitrequest never asserts; 20 consecutive readdatavalid pulses on m1.
- Mixed contention, MAX_HOLD=1: m0 does continuous writes while m1 does continuous reads. Required: strict alternation m0, m1, m0, m1; mem_write=1 only on m0 cycles; m1_readdatavalid on the cycle after each m1 grant.
- Reset mid-read: assert reset in the same cycle m1's read is accepted. Required: no readdatavalid next cycle; owner=0, so under contention the first grant goes to m0.
